// File: rtl/spi_responder_pkg.sv
// Shared definitions for the SPI responder: FSM encoding and default word size.
package spi_responder_pkg;

  localparam int DEF_DATA_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall
// detection on the synchronized value.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // Shift the raw pin through the chain; remember last synchronized level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder: oversamples SCLK/CS_N/MOSI on CLK, shifts words in
// and out MSB first, and exposes valid/ready word interfaces on the CLK side.
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCLK,
  input  logic              CS_N,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic cs_rise, cs_fall, cs_lvl_unused;
  logic mosi_q, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk(CLK), .rst(RST), .din(SCLK),
    .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
    .clk(CLK), .rst(RST), .din(CS_N),
    .q(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk(CLK), .rst(RST), .din(MOSI),
    .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_state_t        state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-1:0] rx_word;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] tx_hold;
  logic              tx_full;
  logic              start, in_shift, abort, word_done, reload;

  // Frame start, live shifting (an ending frame ignores SCLK), and word end.
  assign start     = (state == IDLE) && cs_fall;
  assign abort     = (state == SHIFT) && cs_rise;
  assign in_shift  = (state == SHIFT) && !cs_rise;
  assign word_done = in_shift && sclk_rise && (bit_cnt == CNT_W'(DATA_W-1));
  assign reload    = start || word_done;
  assign rx_word   = {rx_shift, mosi_q};

  assign tx_ready  = ~tx_full;
  assign MISO      = (state == SHIFT) & tx_shift[DATA_W-1];

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state follows the synchronized chip select.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = SHIFT;
      SHIFT:   if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bit counter and receive shifter; an aborted frame drops its partial word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (start) bit_cnt <= '0;
      if (in_shift && sclk_rise) begin
        rx_shift <= rx_word[DATA_W-2:0];
        bit_cnt  <= word_done ? '0 : bit_cnt + CNT_W'(1);
      end
      if (abort) begin
        frame_err <= (bit_cnt != '0);
        bit_cnt   <= '0;
        rx_shift  <= '0;
      end
    end
  end

  // Received-word handoff; a completing word beats a same-cycle consume.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (word_done) begin
        rx_data    <= rx_word;
        rx_valid   <= 1'b1;
        rx_overrun <= rx_valid && !rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // Transmit holding register and shifter. After the last rising edge of a
  // word the counter is back at 0; the falling edge that follows is skipped so
  // the freshly reloaded MSB stays on MISO for the next word's first sample.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_hold     <= '0;
      tx_full     <= 1'b0;
      tx_shift    <= '0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      if (reload) begin
        tx_shift    <= tx_full ? tx_hold : '0;
        tx_underrun <= !tx_full;
        tx_full     <= 1'b0;
      end else if (in_shift && sclk_fall && bit_cnt != '0) begin
        tx_shift <= tx_shift << 1;
      end
      if (tx_valid && !tx_full) begin
        tx_hold <= tx_data;
        tx_full <= 1'b1;
      end
    end
  end

endmodule
